// File: rtl/mem_arbiter_pkg.sv
// Shared CPU definitions for the unified-memory arbiter: FSM states, owner
// encoding and default bus widths.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// DM has priority; a streak counter guarantees IF a grant after STARVE_MAX losses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_en,
  output logic              mem_wr_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 2);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;
  logic              grant_if;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      streak_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    // IF wins when DM is absent or IF has already lost STARVE_MAX times in a row
    grant_if   = if_req && (!dm_req || (streak_q == SW'(STARVE_MAX)));

    case (state_q)
      IDLE: begin
        if (!if_req) streak_d = '0;
        if (if_req || dm_req) begin
          state_d = ACCESS;
          cnt_d   = CW'(MEM_LAT - 1);
          if (grant_if) begin
            owner_d  = OWN_IF;
            addr_d   = if_addr;
            wdata_d  = '0;
            we_d     = 1'b0;
            streak_d = '0;
          end else begin
            owner_d = OWN_DM;
            addr_d  = dm_addr;
            wdata_d = dm_wdata;
            we_d    = dm_we;
            if (if_req) streak_d = streak_q + 1'b1;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (owner_q == OWN_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            dm_valid_d = 1'b1;
            if (!we_q) dm_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_en    = (state_q == ACCESS);
  assign mem_wr_n  = ~((state_q == ACCESS) && we_q);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  // Uses the registered valids so a completing port releases stall in its valid cycle
  assign stall     = (if_req & ~if_valid_q) | (dm_req & ~dm_valid_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner-case sequences and
// a randomized run against a transaction-level arbitration model.
module tb_mem_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int LAT  = 2;
  localparam int SMAX = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] dm_wdata, if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic          if_valid, dm_valid, mem_en, mem_wr_n, stall;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_en(mem_en), .mem_wr_n(mem_wr_n), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall)
  );

  // Memory model: asynchronous read, write commits after LAT consecutive strobe cycles
  logic [DW-1:0] mem [0:65535];
  int            wcnt = 0;
  assign mem_rdata = mem[mem_addr];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic          dm;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t    vecs [8];
  bit      order_q [$];
  logic [DW-1:0] ref_mem [0:31];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    if (mem_en && !mem_wr_n) begin
      wcnt++;
      if (wcnt == LAT) begin
        mem[mem_addr] = mem_wdata;
        wcnt = 0;
      end
    end else begin
      wcnt = 0;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic do_txn(input logic dm, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd, input string nm);
    int lat = 0, en_n = 0, wr_n = 0, stall_bad = 0, other_v = 0, addr_bad = 0;
    logic v;
    tick();
    if (dm) begin dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata; end
    else    begin if_req = 1'b1; if_addr = addr; end
    #1 chk({nm, " stall_at_req"}, 32'(stall), 32'd1);
    for (int k = 1; k <= LAT + 4 && lat == 0; k++) begin
      tick();
      en_n    += int'(mem_en);
      wr_n    += int'(!mem_wr_n);
      v        = dm ? dm_valid : if_valid;
      other_v += int'(dm ? if_valid : dm_valid);
      if (mem_en && mem_addr !== addr) addr_bad++;
      if (v) lat = k;
      else if (!stall) stall_bad++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(LAT + 1));
    chk({nm, " rdata"}, 32'(dm ? dm_rdata : if_rdata), 32'(exp_rd));
    chk({nm, " stall_at_valid"}, 32'(stall), 32'd0);
    dm_req = 1'b0; if_req = 1'b0; dm_we = 1'b0;
    chk({nm, " mem_en_cycles"}, 32'(en_n), 32'(LAT));
    chk({nm, " wr_strobe_cycles"}, 32'(wr_n), we ? 32'(LAT) : 32'd0);
    chk({nm, " other_valid"}, 32'(other_v), 32'd0);
    chk({nm, " stall_waiting"}, 32'(stall_bad), 32'd0);
    chk({nm, " mem_addr"}, 32'(addr_bad), 32'd0);
    tick();
    chk({nm, " valid_one_cycle"}, 32'(dm ? dm_valid : if_valid), 32'd0);
    if (we) chk({nm, " mem_written"}, 32'(mem[addr]), 32'(wdata));
    $display("txn %s port=%s we=%0d addr=%h wdata=%h rdata=%h lat=%0d", nm,
             dm ? "DM" : "IF", we, addr, wdata, dm ? dm_rdata : if_rdata, lat);
  endtask

  // Cycle-level run with a grant-level model: who wins each free slot, and when it completes
  task automatic run_engine(input int ncyc, input bit sat);
    bit            if_p = 0, dm_p = 0, dm_w = 0, vdm = 0, gwe = 0, acc, exp_ifv, exp_dmv;
    logic [AW-1:0] if_a = '0, dm_a = '0, gaddr = '0;
    logic [DW-1:0] dm_d = '0, exp_if_rd = '0, exp_dm_rd = '0;
    int            free_at = 0, vcyc = -1, g = -1000, waits = 0;
    apply_reset();
    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = 16'($urandom);
      mem[i]     = ref_mem[i];
    end
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      tick();
      acc     = (cyc >= g + 1) && (cyc <= g + LAT);
      exp_ifv = (cyc == vcyc) && !vdm;
      exp_dmv = (cyc == vcyc) && vdm;
      chk("eng mem_en", 32'(mem_en), 32'(acc));
      chk("eng mem_wr_n", 32'(mem_wr_n), 32'(!(acc && gwe)));
      if (acc) chk("eng mem_addr", 32'(mem_addr), 32'(gaddr));
      chk("eng if_valid", 32'(if_valid), 32'(exp_ifv));
      chk("eng dm_valid", 32'(dm_valid), 32'(exp_dmv));
      chk("eng stall", 32'(stall), 32'((if_p && !exp_ifv) || (dm_p && !exp_dmv)));
      if (cyc == vcyc) begin
        if (vdm) begin
          chk("eng dm_rdata", 32'(dm_rdata), 32'(exp_dm_rd));
          dm_p = 0;
        end else begin
          chk("eng if_rdata", 32'(if_rdata), 32'(exp_if_rd));
          if_p = 0;
        end
        order_q.push_back(vdm);
        $display("txn eng cyc=%0d port=%s we=%0d addr=%h if_rdata=%h dm_rdata=%h", cyc,
                 vdm ? "DM" : "IF", gwe, gaddr, if_rdata, dm_rdata);
      end
      if (!if_p && (sat || $urandom_range(0, 2) == 0)) begin
        if_p = 1; if_a = 16'($urandom_range(0, 31));
      end
      if (!dm_p && (sat || $urandom_range(0, 2) == 0)) begin
        dm_p = 1; dm_w = 1'($urandom_range(0, 1));
        dm_a = 16'($urandom_range(0, 31)); dm_d = 16'($urandom);
      end
      if_req = if_p; if_addr = if_a;
      dm_req = dm_p; dm_we = dm_w; dm_addr = dm_a; dm_wdata = dm_d;
      if (cyc >= free_at) begin
        if (!if_p) waits = 0;
        if (if_p || dm_p) begin
          vdm = dm_p && !(if_p && waits == SMAX);
          if (vdm) begin
            if (if_p) waits++;
            gaddr = dm_a; gwe = dm_w;
            if (dm_w) ref_mem[dm_a[4:0]] = dm_d;
            else      exp_dm_rd = ref_mem[dm_a[4:0]];
          end else begin
            waits = 0; gaddr = if_a; gwe = 0;
            exp_if_rd = ref_mem[if_a[4:0]];
          end
          g = cyc; vcyc = cyc + LAT + 1; free_at = cyc + LAT + 2;
        end
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
  endtask

  initial begin
    bit exp_order [6];
    int lat;

    apply_reset();
    chk("rst mem_en", 32'(mem_en), 32'd0);
    chk("rst mem_wr_n", 32'(mem_wr_n), 32'd1);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst if_rdata", 32'(if_rdata), 32'd0);
    chk("rst dm_rdata", 32'(dm_rdata), 32'd0);
    chk("rst valids", 32'({if_valid, dm_valid}), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);

    mem[16'h0040] = 16'hBEEF;
    mem[16'h0000] = 16'h8123;
    mem[16'h0012] = 16'h0000;
    vecs[0] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b1, 16'h0012, 16'h1234, 16'hBEEF};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h8123};
    vecs[3] = '{1'b1, 1'b0, 16'h0012, 16'h0000, 16'h1234};
    vecs[4] = '{1'b0, 1'b0, 16'h0012, 16'h0000, 16'h1234};
    vecs[5] = '{1'b1, 1'b1, 16'h0040, 16'h5555, 16'h1234};
    vecs[6] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'h5555};
    vecs[7] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h5555};
    for (int i = 0; i < 8; i++)
      do_txn(vecs[i].dm, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
             $sformatf("vec%0d", i));

    // Request dropped one cycle after grant
    mem[16'h0050] = 16'hC0DE;
    tick();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0050;
    tick();
    dm_req = 1'b0;
    lat = 0;
    for (int k = 2; k <= LAT + 4 && lat == 0; k++) begin
      tick();
      if (dm_valid) lat = k;
    end
    chk("drop latency", 32'(lat), 32'(LAT + 1));
    chk("drop dm_rdata", 32'(dm_rdata), 32'hC0DE);
    tick();
    chk("drop valid_gone", 32'(dm_valid), 32'd0);
    chk("drop idle mem_en", 32'(mem_en), 32'd0);
    $display("txn drop port=DM addr=0050 rdata=%h lat=%0d", dm_rdata, lat);

    // Reset during the first ACCESS cycle of a store
    mem[16'h0030] = 16'hAAAA;
    tick();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0030; dm_wdata = 16'h7777;
    tick();
    chk("rstmid access_started", 32'({mem_en, mem_wr_n}), 32'b10);
    rst = 1'b1; dm_req = 1'b0; dm_we = 1'b0;
    tick();
    chk("rstmid mem_en", 32'(mem_en), 32'd0);
    chk("rstmid mem_wr_n", 32'(mem_wr_n), 32'd1);
    chk("rstmid mem_addr", 32'(mem_addr), 32'd0);
    chk("rstmid mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rstmid rdata", 32'({if_rdata, dm_rdata}), 32'd0);
    chk("rstmid valids", 32'({if_valid, dm_valid}), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < LAT + 1; k++) begin
      tick();
      chk("rstmid no_valid", 32'(dm_valid), 32'd0);
      chk("rstmid no_strobe", 32'(mem_wr_n), 32'd1);
    end
    chk("rstmid mem_unchanged", 32'(mem[16'h0030]), 32'hAAAA);
    $display("txn rstmid port=DM we=1 addr=0030 mem=%h", mem[16'h0030]);

    // Contention: both ports saturated, DM twice then IF, and the streak restarts
    order_q.delete();
    run_engine(30, 1'b1);
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    chk("contend count", 32'(order_q.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < order_q.size(); i++)
      chk($sformatf("contend grant%0d", i), 32'(order_q[i]), 32'(exp_order[i]));

    // Randomized traffic
    order_q.delete();
    run_engine(600, 1'b0);
    chk("random progress", 32'(order_q.size() > 50), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter sharing one single-port unified memory between the fetch stage (IF port) and the load/store stage (DM port) of the 16-bit CPU. It grants one access at a time and holds the memory interface for a fixed access latency. It returns read data with a one-cycle valid pulse and drives a pipeline stall while any request is outstanding. Data accesses have priority over fetches, with a starvation limit so fetch always makes progress.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 2, cycles the memory needs per access (≥1)
- STARVE_MAX, 2, consecutive DM grants allowed while IF waits
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction
- if_valid  out  1  one-cycle completion pulse
- dm_req  in  1  data request, held until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data
- dm_valid  out  1  one-cycle completion pulse
- mem_en  out  1  memory enable
- mem_wr_n  out  1  memory write strobe, active low
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in the last ACCESS cycle
- stall  out  1  (if_req & ~if_valid) | (dm_req & ~dm_valid), combinational

## Operation
- FSM states:
  - IDLE → ACCESS when any request is present.
  - ACCESS holds for MEM_LAT cycles, then → RESP.
  - RESP → IDLE unconditionally.
- Grant in IDLE:
  - DM wins, unless if_req is pending and streak == STARVE_MAX; then IF wins.
  - On grant, latch the owner, address, wdata and we (we = 0 for IF).
- streak counter:
  - Increments on a DM grant made while if_req is high.
  - Clears on any IF grant, and whenever if_req is low in IDLE.
- ACCESS:
  - mem_en = 1 and mem_addr/mem_wdata come from the latches.
  - mem_wr_n = ~latched_we for every ACCESS cycle; it is 1 outside ACCESS.
  - Down-counter loads MEM_LAT-1 on grant; leave ACCESS when it reaches 0.
  - On the final ACCESS cycle of a read, capture mem_rdata into the owner's rdata register.
- RESP: pulse the owner's valid for exactly one cycle.
  - dm_rdata is updated only on loads and holds its previous value on stores.
  - if_rdata/dm_rdata hold their value until the next read by the same port.
- Request dropped mid-access: the access still completes and valid still pulses. Requesters must keep req/addr/data stable until valid.
- Simultaneous if_req and dm_req in IDLE: grant follows the priority and streak rule; the loser waits with stall high.
- Reset mid-access aborts the access: no valid pulse, memory is released the next cycle, and no write strobe occurs after reset.

## Timing
- A request seen in IDLE at cycle T:
  - ACCESS runs T+1 … T+MEM_LAT.
  - valid pulses at T+MEM_LAT+1.
  - The next grant can occur at T+MEM_LAT+2.
- Back-to-back throughput: one access per MEM_LAT+2 cycles.
- Reset values: state = IDLE, mem_en = 0, mem_wr_n = 1, mem_addr = 0, mem_wdata = 0, if_rdata = 0, dm_rdata = 0, if_valid = 0, dm_valid = 0, streak = 0, counter = 0.
- stall is combinational from the inputs and the registered valid outputs, so it is never registered ahead of valid.

## Structure
- The shared CPU package holds:
  - the arb_state_t enum (IDLE, ACCESS, RESP)
  - the owner encoding (OWN_IF, OWN_DM)
  - the ADDR_W/DATA_W defaults
- Single module with no sub-modules; the FSM, latches, latency counter and streak counter live in one file.

## Test plan
- Single load: dm_req = 1, dm_we = 0, dm_addr = 0x0040, memory[0x40] = 0xBEEF, MEM_LAT = 2 → mem_en high for 2 cycles, dm_valid at T+3 with dm_rdata = 0xBEEF, stall high T…T+2.
- Store: dm_we = 1, addr 0x0012, wdata 0x1234 → mem_wr_n low exactly 2 cycles, memory[0x12] = 0x1234, dm_valid pulses once, dm_rdata unchanged.
- Contention: if_req and dm_req both high from T → DM granted first; with STARVE_MAX = 2 and dm_req held across two further DM requests, the third grant goes to IF, if_valid arrives, and streak resets to 0.
- Fetch alone: if_req = 1, if_addr = 0x0000, memory[0] = 0x8123 → if_valid at T+3 with if_rdata = 0x8123, mem_wr_n stays 1.
- Reset mid-access: assert rst in the first ACCESS cycle of a store → no dm_valid, mem_wr_n = 1 and mem_en = 0 the next cycle, memory unchanged at the final ACCESS cycle, and all outputs at reset values.
- Request dropped: deassert dm_req one cycle after grant → access completes and dm_valid still pulses at T+3; FSM returns to IDLE.
